bit_packer: RTL and testbench

//   Collects a serial 1-bit stream, such as the o0 output of a mod0 cell, into

---
 rtl/bit_packer_if.sv | 28 ++
 rtl/bit_packer.sv | 121 ++++++++++++
 tb/tb_bit_packer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_packer_if.sv
// Handshake bundle between the serial bit source, the packer and the word consumer.
interface bit_packer_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_count;
   logic             busy;

   // Environment side: produces bits, consumes words.
   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, busy
   );

   // Packer side.
   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, busy
   );
endinterface

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: gathers accepted bits into WIDTH-bit words
// (early close on in_last) and queues completed words in a DEPTH-entry FIFO.
module bit_packer #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic       clk,
   input logic       rst_n,
   bit_packer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   // Partial word under construction
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;

   // Output FIFO storage and bookkeeping
   logic [WIDTH-1:0] mem_data_q [DEPTH];
   logic [CW-1:0]    mem_cnt_q  [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]    occ_q, occ_d;

   logic             full;
   logic             empty;
   logic             in_ready;
   logic             accept;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] push_word;
   logic [CW-1:0]    push_cnt;
   int unsigned      cur_k;
   int unsigned      slot;

   // Input side: place the accepted bit and decide whether the word closes
   always_comb begin
      full      = (occ_q == OW'(DEPTH));
      empty     = (occ_q == '0);
      in_ready  = rst_n & ~full;
      accept    = bus.in_valid & in_ready;
      cur_k     = 32'(cnt_q);
      slot      = MSB_FIRST ? (WIDTH - 1 - cur_k) : cur_k;
      push_word = word_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i == slot) begin
            push_word[i] = bus.in_bit;
         end
      end
      push_cnt  = cnt_q + CW'(1);
      push      = accept & ((cnt_q == CW'(WIDTH - 1)) | bus.in_last);
      cnt_d     = cnt_q;
      word_d    = word_q;
      if (push) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (accept) begin
         cnt_d  = push_cnt;
         word_d = push_word;
      end
   end

   // FIFO pointer and occupancy update; simultaneous push/pop keeps occupancy
   always_comb begin
      pop      = rst_n & ~empty & bus.out_ready;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         word_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // FIFO storage write; contents are masked by the occupancy so need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= push_word;
         mem_cnt_q[wr_ptr_q]  <= push_cnt;
      end
   end

   // Output drive: head entry when non-empty, zeros otherwise and during reset
   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = rst_n & ~empty;
      bus.out_data  = '0;
      bus.out_count = '0;
      if (rst_n && !empty) begin
         bus.out_data  = mem_data_q[rd_ptr_q];
         bus.out_count = mem_cnt_q[rd_ptr_q];
      end
      bus.busy = rst_n & ((cnt_q != '0) | ~empty);
   end
endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: two instances (MSB-first and LSB-first) share one
// stimulus stream; a per-instance bit-level model feeds expected-word queues.
module tb_bit_packer;
   localparam int W = 4;
   localparam int D = 2;

   logic clk;
   logic rst_n;

   bit_packer_if #(.WIDTH(W)) ifa ();
   bit_packer_if #(.WIDTH(W)) ifb ();

   bit_packer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   bit_packer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int pops_a = 0;
   logic [6:0] qa[$];
   logic [6:0] qb[$];
   logic [3:0] mw[2];
   int         mn[2];

   // Reference model: one accepted bit for instance 'which' (0 = MSB first)
   task automatic model_bit(input int which, input logic b, input logic l);
      int slot;
      slot = (which == 0) ? (W - 1 - mn[which]) : mn[which];
      mw[which][slot] = b;
      mn[which]++;
      if (mn[which] == W || l) begin
         if (which == 0) qa.push_back({3'(mn[which]), mw[which]});
         else            qb.push_back({3'(mn[which]), mw[which]});
         mn[which] = 0;
         mw[which] = '0;
      end
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      mw[0] = '0; mw[1] = '0;
      mn[0] = 0;  mn[1] = 0;
   endtask

   // One clock cycle from a falling edge: scoreboard check of both heads,
   // drive inputs, update the model on acceptance, advance to next falling edge.
   task automatic drive_cycle(input logic v, input logic b, input logic l,
                              input logic r, output logic acc);
      logic [6:0] exp_a, exp_b;
      int occ_a, occ_b;
      occ_a = qa.size();
      occ_b = qb.size();
      exp_a = (occ_a != 0) ? qa[0] : 7'd0;
      exp_b = (occ_b != 0) ? qb[0] : 7'd0;
      ifa.out_ready = r;
      ifb.out_ready = r;
      #1;
      n_vec++;
      if (ifa.in_ready !== (occ_a < D)) begin
         n_err++;
         $display("FAIL in_ready_msb: got %b want %b", ifa.in_ready, (occ_a < D));
      end
      n_vec++;
      if (ifb.in_ready !== (occ_b < D)) begin
         n_err++;
         $display("FAIL in_ready_lsb: got %b want %b", ifb.in_ready, (occ_b < D));
      end
      n_vec++;
      if (ifa.out_valid !== (occ_a != 0) || ifb.out_valid !== (occ_b != 0)) begin
         n_err++;
         $display("FAIL out_valid: got %b/%b want %b/%b", ifa.out_valid, ifb.out_valid,
                  (occ_a != 0), (occ_b != 0));
      end
      n_vec++;
      if (ifa.busy !== (occ_a != 0 || mn[0] != 0) || ifb.busy !== (occ_b != 0 || mn[1] != 0)) begin
         n_err++;
         $display("FAIL busy: got %b/%b want %b/%b", ifa.busy, ifb.busy,
                  (occ_a != 0 || mn[0] != 0), (occ_b != 0 || mn[1] != 0));
      end
      n_vec++;
      if ({ifa.out_count, ifa.out_data} !== exp_a) begin
         n_err++;
         $display("FAIL head_msb: got cnt=%0d data=%b want cnt=%0d data=%b",
                  ifa.out_count, ifa.out_data, exp_a[6:4], exp_a[3:0]);
      end
      n_vec++;
      if ({ifb.out_count, ifb.out_data} !== exp_b) begin
         n_err++;
         $display("FAIL head_lsb: got cnt=%0d data=%b want cnt=%0d data=%b",
                  ifb.out_count, ifb.out_data, exp_b[6:4], exp_b[3:0]);
      end
      if (occ_a != 0 && r) begin
         void'(qa.pop_front());
         pops_a++;
      end
      if (occ_b != 0 && r) void'(qb.pop_front());
      ifa.in_valid = v; ifa.in_bit = b; ifa.in_last = l;
      ifb.in_valid = v; ifb.in_bit = b; ifb.in_last = l;
      acc = v & ifa.in_ready;
      if (v && ifa.in_ready === 1'b1) model_bit(0, b, l);
      if (v && ifb.in_ready === 1'b1) model_bit(1, b, l);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      logic acc;
      repeat (6) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifa.in_valid = 0; ifa.in_bit = 0; ifa.in_last = 0; ifa.out_ready = 1;
      ifb.in_valid = 0; ifb.in_bit = 0; ifb.in_last = 0; ifb.out_ready = 1;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({ifa.out_valid, ifa.busy, ifa.in_ready, ifa.out_count, ifa.out_data} !== 10'd0) begin
         n_err++;
         $display("FAIL reset_outputs_msb: got v=%b busy=%b rdy=%b cnt=%0d data=%b want all 0",
                  ifa.out_valid, ifa.busy, ifa.in_ready, ifa.out_count, ifa.out_data);
      end
      n_vec++;
      if ({ifb.out_valid, ifb.busy, ifb.in_ready, ifb.out_count, ifb.out_data} !== 10'd0) begin
         n_err++;
         $display("FAIL reset_outputs_lsb: got v=%b busy=%b rdy=%b cnt=%0d data=%b want all 0",
                  ifb.out_valid, ifb.busy, ifb.in_ready, ifb.out_count, ifb.out_data);
      end
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (ifa.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_release: got %b want 1", ifa.in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_msb_word();
      logic acc;
      logic [3:0] bits = 4'b1011;
      for (int i = 3; i >= 0; i--) drive_cycle(1'b1, bits[i], 1'b0, 1'b1, acc);
      n_vec++;
      if ({ifa.out_valid, ifa.out_count, ifa.out_data} !== {1'b1, 3'd4, 4'b1011}) begin
         n_err++;
         $display("FAIL msb_1011: got v=%b cnt=%0d data=%b want v=1 cnt=4 data=1011",
                  ifa.out_valid, ifa.out_count, ifa.out_data);
      end
      // Early flush after two bits, then a full word closed by in_last on its 4th bit
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
      n_vec++;
      if ({ifa.out_count, ifa.out_data} !== {3'd2, 4'b1100}) begin
         n_err++;
         $display("FAIL msb_flush: got cnt=%0d data=%b want cnt=2 data=1100",
                  ifa.out_count, ifa.out_data);
      end
      bits = 4'b0111;
      for (int i = 3; i >= 0; i--) drive_cycle(1'b1, bits[i], (i == 0), 1'b1, acc);
      n_vec++;
      if ({ifa.out_count, ifa.out_data} !== {3'd4, 4'b0111}) begin
         n_err++;
         $display("FAIL msb_last_full: got cnt=%0d data=%b want cnt=4 data=0111",
                  ifa.out_count, ifa.out_data);
      end
      drain();
   endtask

   task automatic test_lsb_word();
      logic acc;
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, acc);
      n_vec++;
      if ({ifb.out_count, ifb.out_data} !== {3'd4, 4'b0001}) begin
         n_err++;
         $display("FAIL lsb_0001: got cnt=%0d data=%b want cnt=4 data=0001",
                  ifb.out_count, ifb.out_data);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
      n_vec++;
      if ({ifb.out_count, ifb.out_data} !== {3'd2, 4'b0011}) begin
         n_err++;
         $display("FAIL lsb_flush: got cnt=%0d data=%b want cnt=2 data=0011",
                  ifb.out_count, ifb.out_data);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic acc;
      int sent = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc == 14) begin
            n_vec++;
            if (sent !== 8 || ifa.in_ready !== 1'b0 || ifa.out_data !== 4'b1111) begin
               n_err++;
               $display("FAIL full_stall: got sent=%0d rdy=%b data=%b want sent=8 rdy=0 data=1111",
                        sent, ifa.in_ready, ifa.out_data);
            end
         end
         drive_cycle(sent < 12, 1'b1, 1'b0, (cyc >= 14), acc);
         if (acc) sent++;
      end
      n_vec++;
      if (sent !== 12) begin
         n_err++;
         $display("FAIL backpressure_resume: got %0d bits accepted want 12", sent);
      end
      drain();
   endtask

   task automatic test_random_stream();
      logic acc;
      int taken = 0;
      int p0 = pops_a;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, acc);
         if (acc) taken++;
      end
      drain();
      n_vec++;
      if (taken !== 40 || (pops_a - p0) !== 10) begin
         n_err++;
         $display("FAIL random_stream: got %0d bits/%0d words want 40/10", taken, pops_a - p0);
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
      repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
      ifa.in_valid = 0; ifb.in_valid = 0;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_gate: got rdy=%b v=%b want 0/0", ifa.in_ready, ifa.out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({ifa.out_valid, ifa.busy, ifa.in_ready} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_mid: got v=%b busy=%b rdy=%b want 000",
                  ifa.out_valid, ifa.busy, ifa.in_ready);
      end
      model_clear();
      rst_n = 1'b1;
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, acc);
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      n_vec++;
      if ({ifa.out_count, ifa.out_data, ifb.out_data} !== {3'd4, 4'b1101, 4'b1011}) begin
         n_err++;
         $display("FAIL post_reset_word: got cnt=%0d data=%b/%b want cnt=4 data=1101/1011",
                  ifa.out_count, ifa.out_data, ifb.out_data);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_msb_word();
      test_lsb_word();
      test_backpressure();
      test_random_stream();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
